// File: rtl/acq_pkg.sv
// acq_pkg: shared constants for the UART-triggered acquisition block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, command byte constants, parameter defaults.
package acq_pkg;

  // FSM state encoding shared by the deserializer and the trigger top.
  typedef logic [2:0] acq_state_t;
  localparam acq_state_t ST_IDLE   = 3'd0;
  localparam acq_state_t ST_START  = 3'd1;
  localparam acq_state_t ST_DATA   = 3'd2;
  localparam acq_state_t ST_STOP   = 3'd3;
  localparam acq_state_t ST_WINDOW = 3'd4;

  // Command bytes: 'w' arms channel 0, 'i' arms channel 1.
  localparam logic [7:0] CMD_W = 8'h77;
  localparam logic [7:0] CMD_I = 8'h69;

  localparam int DEF_CLKS_PER_BIT  = 50;
  localparam int DEF_N_CH          = 2;
  localparam int DEF_WINDOW_CYCLES = 72170;
  localparam int DEF_WAVE_W        = 16;
  // Entry k lives in bits [8k+7:8k]; entry 0 is the low byte.
  localparam logic [15:0] DEF_CMD_CODES = {CMD_I, CMD_W};

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 deserializer with 2-FF input synchronizer and START/DATA/STOP FSM.
// Latency: char valid one cycle after the stop-bit sample (~9.5 bit times after start edge).
// Backpressure: none; i_hold blocks new frames from starting, bytes seen while held are lost.
//
// Ports: clk, rst_n (async, active low); i_rx serial line (idle high);
//        i_hold inhibits start detection; o_char/o_char_vld received byte + 1-cycle pulse;
//        o_frame_err 1-cycle pulse on low stop bit (only with ACQ_FRAME_CHECK_EN defined);
//        o_state current deserializer state.
module uart_rx_core
  import acq_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  input  logic       i_hold,
  output logic [7:0] o_char,
  output logic       o_char_vld,
  output logic       o_frame_err,
  output logic [2:0] o_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  acq_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic [7:0]       r_char;
  logic             r_vld;
  logic             r_ferr;
  logic             w_fall;
  logic             w_stop_bad;

  // Edge against the previous synchronized sample: a line that is still low
  // after a window or a framing error must go high before it can re-arm.
  assign w_fall = r_prev & ~r_sync2;

`ifdef ACQ_FRAME_CHECK_EN
  assign w_stop_bad = ~r_sync2;
`else
  assign w_stop_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_char  <= '0;
      r_vld   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_vld   <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fall && !i_hold) begin
            r_state <= ST_START;
            r_cnt   <= '0;
            r_bit   <= '0;
          end
        end
        ST_START: begin
          // Mid-start-bit check rejects glitches shorter than half a bit.
          if (r_cnt == HALF_CNT) begin
            r_cnt   <= '0;
            r_state <= r_sync2 ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_cnt == LAST_CNT) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            if (r_bit == 3'd7) r_state <= ST_STOP;
            else               r_bit   <= r_bit + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (r_cnt == LAST_CNT) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            if (w_stop_bad) begin
              r_ferr <= 1'b1;
            end else begin
              r_char <= r_shift;
              r_vld  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_char      = r_char;
  assign o_char_vld  = r_vld;
  assign o_frame_err = r_ferr;
  assign o_state     = r_state;

endmodule

// File: rtl/uart_acq_trigger.sv
// uart_acq_trigger: UART command byte opens a fixed-length active-low acquire window on one channel.
// Latency: acquire_n asserts the cycle after char_valid; window lasts WINDOW_CYCLES cycles.
// Backpressure: none; serial bytes arriving during a window are dropped.
//
// Ports: clk, rst_n (async, active low); uart_rx serial line; wavenum current waveform number;
//        acquire_n per-channel strobes; last_wavenum wavenum at end of last window;
//        char_out/char_valid last byte + pulse; busy (not idle); frame_err bad stop pulse.
// Build option: define ACQ_FRAME_CHECK_EN to reject frames with a low stop bit.
module uart_acq_trigger
  import acq_pkg::*;
#(
  parameter int                CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
  parameter int                N_CH          = DEF_N_CH,
  parameter logic [N_CH*8-1:0] CMD_CODES     = DEF_CMD_CODES,
  parameter int                WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int                WAVE_W        = DEF_WAVE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  input  logic [WAVE_W-1:0] wavenum,
  output logic [N_CH-1:0]   acquire_n,
  output logic [WAVE_W-1:0] last_wavenum,
  output logic [7:0]        char_out,
  output logic              char_valid,
  output logic              busy,
  output logic              frame_err
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  logic              r_window;
  logic [WIN_W-1:0]  r_win_cnt;
  logic [N_CH-1:0]   r_acq_n;
  logic [WAVE_W-1:0] r_last;
  logic              w_hit;
  logic [CH_W-1:0]   w_ch;
  logic [2:0]        w_rx_state;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rx        (uart_rx),
    .i_hold      (r_window | char_valid),
    .o_char      (char_out),
    .o_char_vld  (char_valid),
    .o_frame_err (frame_err),
    .o_state     (w_rx_state)
  );

  // Scan high to low so the lowest matching table index wins.
  always_comb begin
    w_hit = 1'b0;
    w_ch  = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (char_out == CMD_CODES[k*8 +: 8]) begin
        w_hit = 1'b1;
        w_ch  = CH_W'(k);
      end
    end
  end

  // The channel is held in r_acq_n itself, so wavenum is only looked at
  // on entry (duplicate check) and on the final window cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_window  <= 1'b0;
      r_win_cnt <= '0;
      r_acq_n   <= '1;
      r_last    <= '0;
    end else if (r_window) begin
      if (r_win_cnt == WIN_LAST) begin
        r_window <= 1'b0;
        r_acq_n  <= '1;
        r_last   <= wavenum;
      end else begin
        r_win_cnt <= r_win_cnt + 1'b1;
      end
    end else if (char_valid && w_hit && (wavenum != r_last)) begin
      r_window  <= 1'b1;
      r_win_cnt <= '0;
      r_acq_n   <= ~(N_CH'(1) << w_ch);
    end
  end

  assign acquire_n    = r_acq_n;
  assign last_wavenum = r_last;
  // char_valid covers the decision cycle between the stop sample and WINDOW.
  assign busy         = (w_rx_state != ST_IDLE) | char_valid | r_window;

endmodule

// File: tb/tb_uart_acq_trigger.sv
module tb_uart_acq_trigger;

  localparam int CPB = 50;
  localparam int WIN = 1500;
`ifdef ACQ_FRAME_CHECK_EN
  localparam bit FCHK = 1'b1;
`else
  localparam bit FCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_rx;
  logic [15:0] wavenum;
  logic [1:0]  acquire_n;
  logic [15:0] last_wavenum;
  logic [7:0]  char_out;
  logic        char_valid;
  logic        busy;
  logic        frame_err;

  always #5 clk = ~clk;

  uart_acq_trigger #(
    .CLKS_PER_BIT (CPB),
    .N_CH         (2),
    .CMD_CODES    (16'h6977),
    .WINDOW_CYCLES(WIN),
    .WAVE_W       (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_rx     (uart_rx),
    .wavenum     (wavenum),
    .acquire_n   (acquire_n),
    .last_wavenum(last_wavenum),
    .char_out    (char_out),
    .char_valid  (char_valid),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  // Expected serial events, in send order. ferr=1 means a frame error pulse
  // is expected instead of a received byte.
  typedef struct packed {
    logic [7:0] b;
    logic       ferr;
  } exp_t;
  exp_t expq[$];

  int          checks = 0;
  int          failures = 0;
  logic [1:0]  exp_acq = 2'b11;
  logic [15:0] exp_last = '0;
  logic [15:0] end_wn = '0;
  logic [1:0]  pat = 2'b11;
  int          win_left = 0;
  bit          end_pend = 0;
  bit          exp_idle_next = 0;
  int          n_valid = 0;
  int          n_ferr = 0;
  logic [7:0]  last_char = '0;
  int          run[2];
  int          last_run[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Command table: 'w' -> channel 0, 'i' -> channel 1, else no channel.
  function automatic int cmd_ch(input logic [7:0] b);
    if (b == 8'h77) return 0;
    if (b == 8'h69) return 1;
    return -1;
  endfunction

  // Reference model and per-cycle comparison.
  always @(negedge clk) begin : compare
    exp_t       e;
    int         k;
    logic [1:0] one;
    one = 2'b01;
    if (!rst_n) begin
      expq.delete();
      win_left = 0;
      end_pend = 0;
      exp_idle_next = 0;
      exp_acq = 2'b11;
      exp_last = '0;
      run[0] = 0;
      run[1] = 0;
      chk("rst_acquire_n", acquire_n, 2'b11);
      chk("rst_last_wavenum", last_wavenum, 16'd0);
      chk("rst_char_out", char_out, 8'd0);
      chk("rst_char_valid", char_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_frame_err", frame_err, 1'b0);
    end else begin
      if (win_left > 0) begin
        exp_acq = pat;
        win_left--;
        if (win_left == 0) begin
          end_pend = 1;
          end_wn = wavenum;
        end
      end else if (end_pend) begin
        exp_acq = 2'b11;
        exp_last = end_wn;
        end_pend = 0;
      end
      chk("acquire_n", acquire_n, exp_acq);
      chk("last_wavenum", last_wavenum, exp_last);
      if (exp_acq != 2'b11) chk("busy_in_window", busy, 1'b1);
      if (exp_idle_next) chk("busy_after_byte", busy, 1'b0);
      exp_idle_next = 0;
      for (int c = 0; c < 2; c++) begin
        if (!acquire_n[c]) run[c]++;
        else begin
          if (run[c] > 0) last_run[c] = run[c];
          run[c] = 0;
        end
      end
      if (char_valid) begin
        n_valid++;
        last_char = char_out;
        chk("char_valid_expected", expq.size() != 0, 1'b1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("event_kind_valid", e.ferr, 1'b0);
          chk("char_out", char_out, e.b);
          k = cmd_ch(e.b);
          if (k >= 0 && wavenum != exp_last) begin
            pat = ~(one << k);
            win_left = WIN;
          end else begin
            exp_idle_next = 1;
          end
        end
      end
      if (frame_err) begin
        n_ferr++;
        chk("frame_err_expected", expq.size() != 0, 1'b1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("event_kind_ferr", e.ferr, 1'b1);
        end
      end
    end
  end

  // Each call starts and ends at posedge+2.
  task automatic drive(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input bit push);
    exp_t e;
    e.b = b;
    e.ferr = FCHK & ~stop;
    if (push) expq.push_back(e);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    drive(stop, CPB);
    drive(1'b1, 2 * CPB);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((expq.size() != 0 || win_left != 0 || end_pend || busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle_reached"}, n < 20000, 1'b1);
    if (n >= 20000) expq.delete();
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    #1500000;
    failures++;
    $display("FAIL watchdog actual=time_limit required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int         v0;
    int         v1;
    int         f0;
    int         r;
    logic [7:0] b;
    logic       s;
    last_run[0] = 0;
    last_run[1] = 0;
    rst_n = 1'b0;
    uart_rx = 1'b1;
    wavenum = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_acquire_n", acquire_n, 2'b11);
    chk("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;

    // 'w' with a fresh wavenum opens channel 0.
    wavenum = 16'd5;
    v0 = n_valid;
    send_byte(8'h77, 1'b1, 1);
    chk("w_char_out", last_char, 8'h77);
    chk("w_valid_count", n_valid - v0, 1);
    chk("w_acq_mid", acquire_n, 2'b10);
    wait_idle("w");
    chk("w_window_len", last_run[0], WIN);
    chk("w_last_wavenum", last_wavenum, 16'd5);
    chk("w_acq_end", acquire_n, 2'b11);

    // 'i' with the same wavenum: byte only, no window.
    v0 = n_valid;
    send_byte(8'h69, 1'b1, 1);
    wait_idle("i_same");
    chk("i_same_valid_count", n_valid - v0, 1);
    chk("i_same_no_window", last_run[1], 0);
    chk("i_same_acq", acquire_n, 2'b11);

    // 'i' with a new wavenum opens channel 1; a byte during it is dropped.
    wavenum = 16'd6;
    send_byte(8'h69, 1'b1, 1);
    chk("i_acq_mid", acquire_n, 2'b01);
    v1 = n_valid;
    send_byte(8'h41, 1'b1, 0);
    wait_idle("i_new");
    chk("dropped_byte_valid", n_valid - v1, 0);
    chk("i_window_len", last_run[1], WIN);
    chk("i_last_wavenum", last_wavenum, 16'd6);

    // Non-command byte: received, no window, idle promptly.
    send_byte(8'h41, 1'b1, 1);
    chk("A_char_out", last_char, 8'h41);
    chk("A_busy", busy, 1'b0);
    chk("A_acq", acquire_n, 2'b11);
    wait_idle("A");

    // 10-cycle low glitch is rejected.
    v0 = n_valid;
    drive(1'b0, 10);
    drive(1'b1, 200);
    chk("glitch_valid_count", n_valid - v0, 0);
    chk("glitch_busy", busy, 1'b0);

    // Low stop bit on 'w'.
    wavenum = 16'd11;
    f0 = n_ferr;
    send_byte(8'h77, 1'b0, 1);
    wait_idle("badstop");
`ifdef ACQ_FRAME_CHECK_EN
    chk("badstop_ferr_count", n_ferr - f0, 1);
    chk("badstop_last_wavenum", last_wavenum, 16'd6);
`else
    chk("badstop_ferr_count", n_ferr - f0, 0);
    chk("badstop_last_wavenum", last_wavenum, 16'd11);
`endif

    // wavenum change mid-window keeps the channel; end value is latched.
    wavenum = 16'd7;
    send_byte(8'h77, 1'b1, 1);
    drive(1'b1, WIN / 2);
    wavenum = 16'd8;
    wait_idle("midchange");
    chk("midchange_window_len", last_run[0], WIN);
    chk("midchange_last_wavenum", last_wavenum, 16'd8);

    // Reset around window cycle 1000 clears outputs before the next edge.
    wavenum = 16'd3;
    send_byte(8'h77, 1'b1, 1);
    repeat (880) @(posedge clk);
    #2;
    chk("prereset_acq", acquire_n, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("async_reset_acq", acquire_n, 2'b11);
    chk("async_reset_last", last_wavenum, 16'd0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;

    // Randomized traffic checked by the model.
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 2) == 0) wavenum = 16'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      if (r < 4)      b = 8'h77;
      else if (r < 7) b = 8'h69;
      else            b = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 7) != 0);
      send_byte(b, s, 1);
      if (win_left > 0 && $urandom_range(0, 1) == 1)
        send_byte(8'($urandom_range(0, 255)), 1'b1, 0);
      wait_idle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_acq_trigger.md
UART_ACQ_TRIGGER -- requirements
Module: uart_acq_trigger

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 50, meaning clk cycles per UART bit (50 MHz / 1 Mbaud); legal range >= 4.
REQ-002 SHALL have parameter N_CH, default 2, meaning number of acquisition channels; legal range 1..8.
REQ-003 SHALL have parameter CMD_CODES, default {0x69, 0x77}, meaning N_CH x 8-bit command table; entry k triggers channel k (ch0 = 0x77 'w', ch1 = 0x69 'i').
REQ-004 SHALL have parameter WINDOW_CYCLES, default 72170, meaning acquire-window length in clk cycles.
REQ-005 SHALL have parameter WAVE_W, default 16, meaning wavenum width.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-008 SHALL have port uart_rx, input, 1, meaning asynchronous serial line, idle high.
REQ-009 SHALL have port wavenum, input, WAVE_W, meaning current waveform number from the capture path.
REQ-010 SHALL have port acquire_n, output, N_CH, meaning active-low per-channel acquire strobes.
REQ-011 SHALL have port last_wavenum, output, WAVE_W, meaning wavenum latched at end of last completed window.
REQ-012 SHALL have port char_out, output, 8, meaning last received byte.
REQ-013 SHALL have port char_valid, output, 1, meaning one-cycle pulse when char_out updates.
REQ-014 SHALL have port busy, output, 1, meaning high in any state other than IDLE.
REQ-015 SHALL have port frame_err, output, 1, meaning one-cycle pulse on bad stop bit.

Function
REQ-016 SHALL pass uart_rx through a 2-FF synchronizer (reset value 1) before any use.
REQ-017 SHALL implement the state machine IDLE->START->DATA->STOP->(WINDOW|IDLE), with WINDOW->IDLE.
REQ-018 In IDLE, a synchronized falling edge SHALL enter START and clear the bit counter.
REQ-019 In START, the line SHALL be resampled at CLKS_PER_BIT/2 (integer divide); high = glitch -> IDLE with no outputs changed, low -> DATA.
REQ-020 In DATA, 8 bits SHALL be sampled LSB first, each CLKS_PER_BIT cycles after the previous sample point.
REQ-021 In STOP, the stop bit SHALL be sampled CLKS_PER_BIT after bit 7; on an accepted stop bit, char_out is loaded and char_valid pulses in the same cycle.
REQ-022 The cycle after char_valid, the block SHALL compare char_out against CMD_CODES; on a match at channel k with wavenum != last_wavenum, it SHALL enter WINDOW with acquire_n[k]=0 and all other acquire_n bits 1.
REQ-023 A match on several table entries SHALL select the lowest index.
REQ-024 No match, or wavenum == last_wavenum, SHALL return to IDLE with acquire_n all 1 and last_wavenum unchanged.
REQ-025 acquire_n[k] SHALL stay low for exactly WINDOW_CYCLES cycles; channel and decision are latched, so wavenum changes mid-window have no effect.
REQ-026 In the final WINDOW cycle, the block SHALL load last_wavenum with wavenum; in the next cycle it SHALL set acquire_n all 1 and be in IDLE.
REQ-027 uart_rx activity during WINDOW SHALL be ignored (bytes dropped); IDLE re-arms only after uart_rx is sampled high.
REQ-028 Counters SHALL be $clog2-sized for their maximum value and SHALL never wrap within a state.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, acquire_n all 1, last_wavenum 0, char_out 0, char_valid 0, frame_err 0, busy 0, synchronizer 1s, counters 0; this holds mid-frame and mid-window.

Configuration
REQ-030 The macro ACQ_FRAME_CHECK_EN SHALL select stop-bit checking.
REQ-031 With ACQ_FRAME_CHECK_EN defined, a low stop bit SHALL pulse frame_err for 1 cycle, drop the byte (no char_valid, no window) and return to IDLE.
REQ-032 Without ACQ_FRAME_CHECK_EN, the stop bit SHALL be timed but not checked, and frame_err SHALL be tied 0.

Structure
REQ-033 Package acq_pkg SHALL hold the state enum, CMD_W ('w'=0x77) and CMD_I ('i'=0x69) constants, and default parameter values.
REQ-034 The serial deserializer (sync, START/DATA/STOP) SHALL be sub-module uart_rx_core; uart_acq_trigger holds the match and WINDOW logic.

Verification (CLKS_PER_BIT=50, defaults otherwise)
REQ-035 Send 0x77 with wavenum=5 after reset -> char_valid with char_out=0x77, acquire_n=2'b10 for exactly 72170 cycles, then 2'b11 and last_wavenum=5.
REQ-036 Send 0x69 with wavenum still 5 -> char_valid only, acquire_n stays 2'b11; set wavenum=6 and resend -> acquire_n=2'b01 for 72170 cycles, last_wavenum=6.
REQ-037 Send 0x41 -> char_out=0x41, char_valid pulses, acquire_n 2'b11, busy low within 2 cycles after stop sample.
REQ-038 Drive uart_rx low for 10 cycles -> back to IDLE, no char_valid; a byte sent during WINDOW -> no char_valid.
REQ-039 Send 0x77 with stop bit 0 -> with ACQ_FRAME_CHECK_EN: frame_err pulse, no acquire; without: window as in REQ-035.
REQ-040 Assert rst_n low at window cycle 1000 -> acquire_n=2'b11 and last_wavenum=0 before the next clk edge.
